// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus controller.
//   state_e    : controller FSM encoding (IDLE, BUSY, RESP)
//   *_BASE/*_MASK : default memory map (data memory, IO, external window)
//   len_e      : access length codes issued by the processor MEM stage
//   idx_width(): width of a binary slave index for a given slave count
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Default memory map: 256 B data memory, 32 B IO block, 256 B external window.
    localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] DMEM_MASK = 32'hFFFF_FF00;
    localparam logic [31:0] IO_BASE   = 32'h0000_0100;
    localparam logic [31:0] IO_MASK   = 32'hFFFF_FFE0;
    localparam logic [31:0] EXT_BASE  = 32'h0000_0200;
    localparam logic [31:0] EXT_MASK  = 32'hFFFF_FF00;

    // Length codes as produced by the processor; the controller only forwards them.
    typedef enum logic [2:0] {
        LEN_BYTE   = 3'b000,
        LEN_HALF   = 3'b001,
        LEN_WORD   = 3'b010,
        LEN_BYTE_U = 3'b100,
        LEN_HALF_U = 3'b101
    } len_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Bus bundle between processor MEM stage, controller and slave devices.
//   m_* : processor side (request in, stall/response out of the controller)
//   s_* : device side (broadcast address/data, one-hot select, per-slave ack/data)
// Modports:
//   master : the controller, which masters the device bus and serves the processor
//   slave  : the surroundings (processor plus devices)
interface mem_bus_ctrl_if #(
    parameter int WIDTH    = 32,
    parameter int N_SLAVES = 3
) ();
    logic [WIDTH-1:0]          m_addr;
    logic [WIDTH-1:0]          m_wdata;
    logic [2:0]                m_len;
    logic                      m_rd;
    logic                      m_wr;
    logic                      m_stall;
    logic [WIDTH-1:0]          m_rdata;
    logic                      m_err;
    logic [WIDTH-1:0]          m_err_addr;

    logic [WIDTH-1:0]          s_addr;
    logic [WIDTH-1:0]          s_wdata;
    logic [2:0]                s_len;
    logic                      s_rd;
    logic                      s_wr;
    logic [N_SLAVES-1:0]       s_sel;
    logic [N_SLAVES-1:0]       s_ack;
    logic [N_SLAVES*WIDTH-1:0] s_rdata;

    modport master (
        input  m_addr, m_wdata, m_len, m_rd, m_wr, s_ack, s_rdata,
        output m_stall, m_rdata, m_err, m_err_addr,
               s_addr, s_wdata, s_len, s_rd, s_wr, s_sel
    );

    modport slave (
        output m_addr, m_wdata, m_len, m_rd, m_wr, s_ack, s_rdata,
        input  m_stall, m_rdata, m_err, m_err_addr,
               s_addr, s_wdata, s_len, s_rd, s_wr, s_sel
    );
endinterface

// File: rtl/mem_bus_decoder.sv
// Combinational address decoder.
//   addr       : address to decode
//   base_addrs : packed per-slave base addresses
//   masks      : packed per-slave address masks
//   hit        : some window matched
//   idx        : binary index of the matching slave; lowest index wins on overlap
module mem_bus_decoder
    import mem_bus_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_SLAVES = 3,
    parameter int IDX_W    = idx_width(N_SLAVES)
) (
    input  logic [WIDTH-1:0]          addr,
    input  logic [N_SLAVES*WIDTH-1:0] base_addrs,
    input  logic [N_SLAVES*WIDTH-1:0] masks,
    output logic                      hit,
    output logic [IDX_W-1:0]          idx
);

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        hit = 1'b0;
        idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & masks[i*WIDTH +: WIDTH]) == base_addrs[i*WIDTH +: WIDTH]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-mapped bus controller between the processor MEM stage and N slaves.
// Decodes the request address, selects one slave, waits for its acknowledge
// (or a timeout) and returns registered read data or an error for one cycle.
//   CLK : system clock
//   RST : synchronous active-high reset
//   bus : mem_bus_ctrl_if.master (processor request/response and device bus)
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int                        WIDTH      = 32,
    parameter int                        N_SLAVES   = 3,
    parameter logic [N_SLAVES*WIDTH-1:0] BASE_ADDRS = {EXT_BASE, IO_BASE, DMEM_BASE},
    parameter logic [N_SLAVES*WIDTH-1:0] ADDR_MASKS = {EXT_MASK, IO_MASK, DMEM_MASK},
    parameter int                        TIMEOUT    = 15
) (
    input  logic           CLK,
    input  logic           RST,
    mem_bus_ctrl_if.master bus
);

    localparam int IDX_W = idx_width(N_SLAVES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              state;
    state_e              state_nxt;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;

    logic [WIDTH-1:0]    lat_addr;
    logic [WIDTH-1:0]    lat_wdata;
    logic [2:0]          lat_len;
    logic                lat_rd;
    logic                lat_wr;
    logic [IDX_W-1:0]    lat_idx;
    logic [CNT_W-1:0]    cnt;

    logic [WIDTH-1:0]    rdata_q;
    logic                err_q;
    logic [WIDTH-1:0]    err_addr_q;

    logic                req;
    logic                req_bad;
    logic                sel_ack;
    logic                timed_out;
    logic [N_SLAVES-1:0] sel;

    mem_bus_decoder #(
        .WIDTH    (WIDTH),
        .N_SLAVES (N_SLAVES),
        .IDX_W    (IDX_W)
    ) u_decoder (
        .addr       (bus.m_addr),
        .base_addrs (BASE_ADDRS),
        .masks      (ADDR_MASKS),
        .hit        (hit),
        .idx        (hit_idx)
    );

    assign req       = bus.m_rd | bus.m_wr;
    // Conflicting strobes or an unmapped address never reach a slave.
    assign req_bad   = (bus.m_rd & bus.m_wr) | ~hit;
    // Only the selected slave's acknowledge counts.
    assign sel_ack   = bus.s_ack[lat_idx];
    // cnt holds the number of BUSY cycles already completed, so this fires in
    // the TIMEOUT-th BUSY cycle.
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = req_bad ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (sel_ack || timed_out) begin
                    state_nxt = ST_RESP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_len    <= '0;
            lat_rd     <= 1'b0;
            lat_wr     <= 1'b0;
            lat_idx    <= '0;
            cnt        <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            // Response strobes live for the RESP cycle only.
            rdata_q <= '0;
            err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (req_bad) begin
                            err_q      <= 1'b1;
                            err_addr_q <= bus.m_addr;
                        end else begin
                            lat_addr  <= bus.m_addr;
                            lat_wdata <= bus.m_wdata;
                            lat_len   <= bus.m_len;
                            lat_rd    <= bus.m_rd;
                            lat_wr    <= bus.m_wr;
                            lat_idx   <= hit_idx;
                            cnt       <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt != CNT_W'(TIMEOUT)) begin
                        cnt <= cnt + 1'b1;
                    end
                    // Acknowledge takes priority over a coincident timeout.
                    if (sel_ack) begin
                        rdata_q <= lat_rd ? bus.s_rdata[lat_idx*WIDTH +: WIDTH] : '0;
                    end else if (timed_out) begin
                        err_q      <= 1'b1;
                        err_addr_q <= lat_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Select follows the state directly, so it drops on the same edge as a reset.
    always_comb begin
        sel = '0;
        if (state == ST_BUSY) begin
            sel[lat_idx] = 1'b1;
        end
    end

    assign bus.m_stall    = req && (state != ST_RESP);
    assign bus.m_rdata    = rdata_q;
    assign bus.m_err      = err_q;
    assign bus.m_err_addr = err_addr_q;

    assign bus.s_addr     = lat_addr;
    assign bus.s_wdata    = lat_wdata;
    assign bus.s_len      = lat_len;
    assign bus.s_rd       = (state == ST_BUSY) && lat_rd;
    assign bus.s_wr       = (state == ST_BUSY) && lat_wr;
    assign bus.s_sel      = sel;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed accesses, scoreboard of
// expected responses, per-access cycle counts of stall/select/strobes.
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    localparam int W  = 32;
    localparam int NS = 3;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.WIDTH(W), .N_SLAVES(NS)) bus ();

    mem_bus_ctrl #(.WIDTH(W), .N_SLAVES(NS), .TIMEOUT(TO)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] err_addr;
        int          stall;
        int          sel_cycles;
        logic [2:0]  sel;
        int          rd_cycles;
        int          wr_cycles;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_fault = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference memory map written as explicit ranges.
    function automatic int model_slave(input logic [31:0] a);
        if (a < 32'h100) return 0;
        if (a >= 32'h100 && a < 32'h120) return 1;
        if (a >= 32'h200 && a < 32'h300) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] slave_data(input int s);
        case (s)
            0:       return 32'hDEAD_BEEF;
            1:       return 32'h1111_1111;
            default: return 32'h2222_2222;
        endcase
    endfunction

    // One complete access. ack_after < 0 means the slave never acknowledges;
    // noise is a constant ack pattern driven on top (e.g. unselected slaves).
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] len, input int ack_after,
                          input logic [2:0] noise);
        exp_t        e;
        int          s = model_slave(addr);
        int          stall_n = 0, sel_n = 0, rd_n = 0, wr_n = 0;
        logic [2:0]  sel_or = '0;
        logic [31:0] addr_seen = '0, wdata_seen = '0;
        logic [2:0]  len_seen = '0;
        logic        done = 1'b0;
        logic [31:0] got_rdata = '0, got_err_addr = '0;
        logic        got_err = 1'b0;

        if (s < 0 || (rd && wr)) begin
            e.err = 1'b1; e.rdata = '0; e.stall = 1; e.sel_cycles = 0; e.sel = '0;
            last_fault = addr;
        end else if (ack_after < 0) begin
            e.err = 1'b1; e.rdata = '0; e.stall = TO + 1; e.sel_cycles = TO;
            e.sel = 3'(1 << s);
            last_fault = addr;
        end else begin
            e.err = 1'b0; e.rdata = rd ? slave_data(s) : '0;
            e.stall = ack_after + 2; e.sel_cycles = ack_after + 1;
            e.sel = 3'(1 << s);
        end
        e.err_addr  = last_fault;
        e.rd_cycles = (e.sel != 0 && rd) ? e.sel_cycles : 0;
        e.wr_cycles = (e.sel != 0 && wr) ? e.sel_cycles : 0;
        sb.push_back(e);

        @(posedge clk); #1;
        bus.m_rd = rd; bus.m_wr = wr; bus.m_addr = addr; bus.m_wdata = wdata; bus.m_len = len;
        bus.s_ack = noise;

        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (bus.m_stall) stall_n++;
            if (bus.s_rd) rd_n++;
            if (bus.s_wr) wr_n++;
            if (bus.s_sel != '0) begin
                sel_n++;
                sel_or     = sel_or | bus.s_sel;
                addr_seen  = bus.s_addr;
                wdata_seen = bus.s_wdata;
                len_seen   = bus.s_len;
            end
            if (!bus.m_stall) begin
                done         = 1'b1;
                got_rdata    = bus.m_rdata;
                got_err      = bus.m_err;
                got_err_addr = bus.m_err_addr;
            end
            if (bus.s_sel != '0 && ack_after >= 0 && sel_n == ack_after + 1)
                bus.s_ack = bus.s_sel | noise;
            else
                bus.s_ack = noise;
        end

        check({tag, "_resp_seen"}, 32'(done), 32'd1);
        e = sb.pop_front();
        check({tag, "_rdata"},      got_rdata,      e.rdata);
        check({tag, "_err"},        32'(got_err),   32'(e.err));
        check({tag, "_err_addr"},   got_err_addr,   e.err_addr);
        check({tag, "_stall_cyc"},  32'(stall_n),   32'(e.stall));
        check({tag, "_sel_cyc"},    32'(sel_n),     32'(e.sel_cycles));
        check({tag, "_sel"},        32'(sel_or),    32'(e.sel));
        check({tag, "_rd_cyc"},     32'(rd_n),      32'(e.rd_cycles));
        check({tag, "_wr_cyc"},     32'(wr_n),      32'(e.wr_cycles));
        if (e.sel != '0) begin
            check({tag, "_s_addr"}, addr_seen,      addr);
            check({tag, "_s_len"},  32'(len_seen),  32'(len));
            if (wr) check({tag, "_s_wdata"}, wdata_seen, wdata);
        end

        @(posedge clk); #1;
        bus.m_rd = 1'b0; bus.m_wr = 1'b0; bus.s_ack = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sel_n;
        int          err_n;
        logic        got2;

        rst = 1'b1;
        bus.m_addr = '0; bus.m_wdata = '0; bus.m_len = '0; bus.m_rd = 1'b0; bus.m_wr = 1'b0;
        bus.s_ack = '0;
        bus.s_rdata = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall",    32'(bus.m_stall), 32'd0);
        check("rst_sel",      32'(bus.s_sel),   32'd0);
        check("rst_err",      32'(bus.m_err),   32'd0);
        check("rst_rdata",    bus.m_rdata,      32'd0);
        check("rst_err_addr", bus.m_err_addr,   32'd0);
        check("rst_s_addr",   bus.s_addr,       32'd0);
        @(posedge clk); #1 rst = 1'b0;

        access("rd_s0",    1'b1, 1'b0, 32'h0000_0010, 32'h0,  LEN_WORD,  0, 3'b000);
        access("wr_s1",    1'b0, 1'b1, 32'h0000_0104, 32'h55, LEN_BYTE,  3, 3'b000);
        access("unmapped", 1'b1, 1'b0, 32'h0000_1000, 32'h0,  LEN_WORD,  0, 3'b000);
        access("timeout",  1'b1, 1'b0, 32'h0000_0200, 32'h0,  LEN_WORD, -1, 3'b011);
        access("rd_wr",    1'b1, 1'b1, 32'h0000_0000, 32'h0,  LEN_WORD,  0, 3'b000);
        access("io_edge",  1'b1, 1'b0, 32'h0000_011C, 32'h0,  LEN_HALF,  0, 3'b000);
        access("io_past",  1'b0, 1'b1, 32'h0000_0120, 32'h7,  LEN_WORD,  0, 3'b000);

        // Reset in the second BUSY cycle of a slave0 read.
        @(posedge clk); #1;
        bus.m_rd = 1'b1; bus.m_addr = 32'h0000_0040; bus.m_len = LEN_WORD;
        sel_n = 0;
        got2  = 1'b0;
        for (int c = 0; c < 10 && !got2; c++) begin
            @(negedge clk);
            if (bus.s_sel != '0) sel_n++;
            if (sel_n == 2) begin
                got2 = 1'b1;
                rst  = 1'b1;
            end
        end
        check("mid_rst_reached", 32'(got2), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; bus.m_rd = 1'b0;
        @(negedge clk);
        check("mid_rst_sel",      32'(bus.s_sel),  32'd0);
        check("mid_rst_err",      32'(bus.m_err),  32'd0);
        check("mid_rst_err_addr", bus.m_err_addr,  32'd0);
        last_fault = 32'h0;
        err_n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.m_err || bus.s_sel != '0) err_n++;
        end
        check("mid_rst_no_resp", 32'(err_n), 32'd0);

        access("post_rst", 1'b1, 1'b0, 32'h0000_0008, 32'h0, LEN_WORD, 0, 3'b000);
        access("rd_s2",    1'b1, 1'b0, 32'h0000_02F0, 32'h0, LEN_WORD, 1, 3'b001);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
